uart_cmd_decoder: RTL and testbench

//  Frame parser directly downstream of the UART receiver. Consumes received bytes
//  (p_data + data_valid + error flags), decodes multi-byte command frames and issues

---
 rtl/uart_cmd_decoder_if.sv | 28 ++
 rtl/uart_cmd_decoder.sv | 135 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Receiver-side byte stream and system-side register-file/ALU strobes of the command decoder.
// The decoder drives the system side through the master modport; its environment uses slave.
interface uart_cmd_decoder_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [7:0]        rx_p_data;
    logic              rx_d_valid;
    logic              parity_error;
    logic              stop_error;
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wr_data;
    logic              alu_en;
    logic [3:0]        alu_fun;
    logic              clk_gate_en;
    logic              cmd_error;

    modport master (
        input  rx_p_data, rx_d_valid, parity_error, stop_error,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en, cmd_error
    );

    modport slave (
        output rx_p_data, rx_d_valid, parity_error, stop_error,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, clk_gate_en, cmd_error
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses UART command frames (WR, RD, ALU_OP, ALU_NOP) into registered single-cycle
// register-file and ALU strobes; any receiver error byte aborts the frame.
module uart_cmd_decoder #(
    parameter int unsigned ADDR_W      = 4,
    parameter logic [7:0]  CMD_WR      = 8'hAA,
    parameter logic [7:0]  CMD_RD      = 8'hBB,
    parameter logic [7:0]  CMD_ALU_OP  = 8'hCC,
    parameter logic [7:0]  CMD_ALU_NOP = 8'hDD
) (
    input logic                CLK,
    input logic                RST,
    uart_cmd_decoder_if.master bus
);
    localparam int unsigned FUN_W = 4;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [7:0]        rf_wr_data_q, rf_wr_data_d;
    logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic              alu_en_q, alu_en_d;
    logic              clk_gate_en_q, clk_gate_en_d;
    logic              cmd_error_q, cmd_error_d;
    logic              byte_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rf_addr_q     <= '0;
            rf_wr_data_q  <= '0;
            alu_fun_q     <= '0;
            rf_wr_en_q    <= 1'b0;
            rf_rd_en_q    <= 1'b0;
            alu_en_q      <= 1'b0;
            clk_gate_en_q <= 1'b0;
            cmd_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rf_addr_q     <= rf_addr_d;
            rf_wr_data_q  <= rf_wr_data_d;
            alu_fun_q     <= alu_fun_d;
            rf_wr_en_q    <= rf_wr_en_d;
            rf_rd_en_q    <= rf_rd_en_d;
            alu_en_q      <= alu_en_d;
            clk_gate_en_q <= clk_gate_en_d;
            cmd_error_q   <= cmd_error_d;
        end
    end

    // Error bytes take priority in every state; opcodes only decode in IDLE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_fun_d    = alu_fun_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        cmd_error_d  = 1'b0;
        byte_err     = bus.parity_error | bus.stop_error;

        if (bus.rx_d_valid) begin
            if (byte_err) begin
                cmd_error_d = 1'b1;
                state_d     = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        case (bus.rx_p_data)
                            CMD_WR:      state_d = WR_ADDR;
                            CMD_RD:      state_d = RD_ADDR;
                            CMD_ALU_OP:  state_d = ALU_A;
                            CMD_ALU_NOP: state_d = ALU_FUN;
                            default:     cmd_error_d = 1'b1;
                        endcase
                    end
                    WR_ADDR: begin
                        addr_d  = bus.rx_p_data[ADDR_W-1:0];
                        state_d = WR_DATA;
                    end
                    WR_DATA: begin
                        rf_addr_d    = addr_q;
                        rf_wr_data_d = bus.rx_p_data;
                        rf_wr_en_d   = 1'b1;
                        state_d      = IDLE;
                    end
                    RD_ADDR: begin
                        rf_addr_d  = bus.rx_p_data[ADDR_W-1:0];
                        rf_rd_en_d = 1'b1;
                        state_d    = IDLE;
                    end
                    ALU_A: begin
                        rf_addr_d    = '0;
                        rf_wr_data_d = bus.rx_p_data;
                        rf_wr_en_d   = 1'b1;
                        state_d      = ALU_B;
                    end
                    ALU_B: begin
                        rf_addr_d    = ADDR_W'(1);
                        rf_wr_data_d = bus.rx_p_data;
                        rf_wr_en_d   = 1'b1;
                        state_d      = ALU_FUN;
                    end
                    ALU_FUN: begin
                        alu_fun_d = bus.rx_p_data[FUN_W-1:0];
                        alu_en_d  = 1'b1;
                        state_d   = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Gate stays open for the whole ALU frame, including the alu_en cycle itself.
        clk_gate_en_d = alu_en_d | (state_d == ALU_A) | (state_d == ALU_B) | (state_d == ALU_FUN);
    end

    assign bus.rf_wr_en    = rf_wr_en_q;
    assign bus.rf_rd_en    = rf_rd_en_q;
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wr_data  = rf_wr_data_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_fun     = alu_fun_q;
    assign bus.clk_gate_en = clk_gate_en_q;
    assign bus.cmd_error   = cmd_error_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus queues expected strobes, a negedge
// monitor pops and compares them whenever the decoder emits one.
module tb_uart_cmd_decoder;
    localparam int unsigned ADDR_W = 4;
    localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ALU = 2'd2, K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
        logic [3:0] fun;
        logic       gate;
    } ev_t;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    uart_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus ();

    uart_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d,
                                 input logic [3:0] f, input logic g);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.fun = f; e.gate = g;
        exp_q.push_back(e);
    endfunction

    task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic se = 1'b0);
        @(negedge CLK);
        bus.rx_p_data    = b;
        bus.rx_d_valid   = 1'b1;
        bus.parity_error = pe;
        bus.stop_error   = se;
    endtask

    task automatic idle();
        @(negedge CLK);
        bus.rx_d_valid   = 1'b0;
        bus.parity_error = 1'b0;
        bus.stop_error   = 1'b0;
    endtask

    // Monitor: every strobe cycle must match the oldest expected event.
    logic [1:0] act_kind;
    int         n_strobes;
    ev_t        e_mon;
    always @(negedge CLK) begin
        if (RST && (bus.rf_wr_en || bus.rf_rd_en || bus.alu_en || bus.cmd_error)) begin
            n_strobes = int'(bus.rf_wr_en) + int'(bus.rf_rd_en) + int'(bus.alu_en) + int'(bus.cmd_error);
            chk("strobe_onehot", 32'(n_strobes), 32'd1);
            act_kind = bus.rf_wr_en ? K_WR : bus.rf_rd_en ? K_RD : bus.alu_en ? K_ALU : K_ERR;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d expected none at %0t", act_kind, $time);
            end else begin
                e_mon = exp_q.pop_front();
                chk("event_kind", 32'(act_kind), 32'(e_mon.kind));
                chk("event_gate", 32'(bus.clk_gate_en), 32'(e_mon.gate));
                if (e_mon.kind == K_WR || e_mon.kind == K_RD)
                    chk("rf_addr", 32'(bus.rf_addr), 32'(e_mon.addr));
                if (e_mon.kind == K_WR)
                    chk("rf_wr_data", 32'(bus.rf_wr_data), 32'(e_mon.data));
                if (e_mon.kind == K_ALU)
                    chk("alu_fun", 32'(bus.alu_fun), 32'(e_mon.fun));
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data,
                    bus.alu_en, bus.alu_fun, bus.clk_gate_en, bus.cmd_error});
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b0;
        bus.rx_p_data    = 8'h00;
        bus.rx_d_valid   = 1'b0;
        bus.parity_error = 1'b0;
        bus.stop_error   = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", all_outs(), 32'd0);
        RST = 1'b1;
        idle();

        // Register write, back-to-back bytes
        push(K_WR, 4'h5, 8'h3C, 4'h0, 1'b0);
        send(8'hAA); send(8'h05); send(8'h3C); idle();

        // Read with address truncation
        push(K_RD, 4'hA, 8'h00, 4'h0, 1'b0);
        send(8'hBB); send(8'h1A); idle();

        // Opcode values inside a frame are data
        push(K_WR, 4'hB, 8'hCC, 4'h0, 1'b0);
        send(8'hAA); send(8'hBB); send(8'hCC); idle();

        // ALU_OP with clock-gate window
        push(K_WR, 4'h0, 8'h12, 4'h0, 1'b1);
        push(K_WR, 4'h1, 8'h34, 4'h0, 1'b1);
        push(K_ALU, 4'h0, 8'h00, 4'h3, 1'b1);
        send(8'hCC); idle();
        chk("gate_after_opcode", 32'(bus.clk_gate_en), 32'd1);
        send(8'h12); send(8'h34); send(8'hF3); idle();
        chk("gate_alu_en_cycle", 32'(bus.clk_gate_en), 32'd1);
        @(negedge CLK);
        chk("gate_after_frame", 32'(bus.clk_gate_en), 32'd0);

        // ALU_NOP, then illegal opcode
        push(K_ALU, 4'h0, 8'h00, 4'h2, 1'b1);
        send(8'hDD); send(8'h02); idle();
        push(K_ERR, 4'h0, 8'h00, 4'h0, 1'b0);
        send(8'h55); idle();

        // Parity error aborts write, next frame decodes normally
        push(K_ERR, 4'h0, 8'h00, 4'h0, 1'b0);
        send(8'hAA); send(8'h05); send(8'h3C, 1'b1, 1'b0); idle();
        push(K_WR, 4'h1, 8'hFF, 4'h0, 1'b0);
        send(8'hAA); send(8'h01); send(8'hFF); idle();

        // Stop error mid ALU frame: operand A write stands, gate drops
        push(K_WR, 4'h0, 8'hAB, 4'h0, 1'b1);
        push(K_ERR, 4'h0, 8'h00, 4'h0, 1'b0);
        send(8'hCC); send(8'hAB); send(8'h34, 1'b0, 1'b1); idle();
        @(negedge CLK);
        chk("gate_after_abort", 32'(bus.clk_gate_en), 32'd0);

        // Asynchronous reset while waiting for operand B
        push(K_WR, 4'h0, 8'h12, 4'h0, 1'b1);
        send(8'hCC); send(8'h12); idle();
        @(negedge CLK);
        chk("gate_before_reset", 32'(bus.clk_gate_en), 32'd1);
        #2 RST = 1'b0;
        #1 chk("async_reset_outputs", all_outs(), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        push(K_ALU, 4'h0, 8'h00, 4'h4, 1'b1);
        send(8'hDD); send(8'h04); idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
